// File: rtl/gf180mcu_fd_sc_mcu9t5v0__prbs_chk_pkg.sv
// Shared definitions for the PRBS7 chain checker: FSM encoding, polynomial taps, LFSR length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gf180mcu_fd_sc_mcu9t5v0__prbs_chk_pkg;

   // Checker FSM encoding; values are fixed so they line up with the library's test documentation.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } prbs_state_t;

   // PRBS7, x^7 + x^6 + 1: the predicted bit is the XOR of the two oldest LFSR bits.
   localparam int PRBS_LEN   = 7;
   localparam int PRBS_TAP_A = 6;
   localparam int PRBS_TAP_B = 5;

   // Next bit expected on the chain, given the last PRBS_LEN bits (bit 0 = newest).
   function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] lfsr);
      return lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B];
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__prbs_chk_func.sv
// Functional core: self-synchronising PRBS7 checker with lock detection and saturating error count.
// Latency: LOCK/ERR/ERR_CNT registered on the edge that samples the deciding bit.
// Backpressure: none; one chain bit is consumed on every rising edge while enabled.
module gf180mcu_fd_sc_mcu9t5v0__prbs_chk_func
   import gf180mcu_fd_sc_mcu9t5v0__prbs_chk_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_ERR = 4,
   parameter int LOSS_WIN = 32,
   parameter int ERR_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_bit,
   input  logic             i_clr,
   output logic             o_lock,
   output logic             o_err,
   output logic [ERR_W-1:0] o_err_cnt
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WERR_W  = $clog2(LOSS_ERR + 1);
   localparam int WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
   localparam int SEED_W  = $clog2(PRBS_LEN);

   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
   localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_ERR);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
   localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_LEN - 1);

   prbs_state_t           r_state;
   prbs_state_t           w_state_nxt;
   logic [PRBS_LEN-1:0]   r_lfsr;
   logic [PRBS_LEN-1:0]   w_lfsr_nxt;
   logic [SEED_W-1:0]     r_seed_cnt;
   logic [SEED_W-1:0]     w_seed_nxt;
   logic [MATCH_W-1:0]    r_match;
   logic [MATCH_W-1:0]    w_match_nxt;
   logic [WIN_W-1:0]      r_win;
   logic [WIN_W-1:0]      w_win_nxt;
   logic [WERR_W-1:0]     r_win_err;
   logic [WERR_W-1:0]     w_win_err_nxt;
   logic                  r_lock;
   logic                  w_lock_nxt;
   logic                  r_err;
   logic                  w_err_nxt;
   logic [ERR_W-1:0]      r_err_cnt;
   logic [ERR_W-1:0]      w_err_cnt_nxt;
   logic                  w_cnt_inc;

   logic                  w_exp;
   logic                  w_mis;
   logic [PRBS_LEN-1:0]   w_shift_in;
   logic [MATCH_W-1:0]    w_match_inc;
   logic [WERR_W-1:0]     w_win_err_inc;
   logic                  w_win_wrap;

   assign w_exp         = prbs_predict(r_lfsr);
   assign w_mis         = i_bit ^ w_exp;
   assign w_shift_in    = {r_lfsr[PRBS_LEN-2:0], i_bit};
   assign w_match_inc   = r_match + MATCH_W'(1);
   assign w_win_err_inc = r_win_err + WERR_W'(w_mis);
   assign w_win_wrap    = (r_win == WIN_LAST);

   // Next-state and next-output decode; EN low overrides every state and forces IDLE.
   always_comb begin
      w_state_nxt   = r_state;
      w_lfsr_nxt    = r_lfsr;
      w_seed_nxt    = r_seed_cnt;
      w_match_nxt   = r_match;
      w_win_nxt     = r_win;
      w_win_err_nxt = r_win_err;
      w_lock_nxt    = r_lock;
      w_err_nxt     = 1'b0;
      w_cnt_inc     = 1'b0;

      if (!i_en) begin
         w_state_nxt   = IDLE;
         w_lock_nxt    = 1'b0;
         w_seed_nxt    = '0;
         w_match_nxt   = '0;
         w_win_nxt     = '0;
         w_win_err_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = SEED;
               w_seed_nxt  = '0;
               w_lock_nxt  = 1'b0;
            end
            SEED: begin
               w_lfsr_nxt = w_shift_in;
               if (r_seed_cnt == SEED_LAST) begin
                  // An all-zero seed is the PRBS lock-up state, so it is never accepted.
                  w_seed_nxt = '0;
                  if (w_shift_in != '0) begin
                     w_state_nxt = VERIFY;
                     w_match_nxt = '0;
                  end
               end else begin
                  w_seed_nxt = r_seed_cnt + SEED_W'(1);
               end
            end
            VERIFY: begin
               w_lfsr_nxt = w_shift_in;
               if (!w_mis) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == MATCH_LOCK) begin
                     w_state_nxt   = LOCKED;
                     w_lock_nxt    = 1'b1;
                     w_win_nxt     = '0;
                     w_win_err_nxt = '0;
                  end
               end else begin
                  // A bad seed is not a chain error; just reseed quietly.
                  w_state_nxt = SEED;
                  w_seed_nxt  = '0;
                  w_match_nxt = '0;
               end
            end
            LOCKED: begin
               // Feed back the prediction so a bad chain bit cannot corrupt the predictor.
               w_lfsr_nxt = {r_lfsr[PRBS_LEN-2:0], w_exp};
               w_win_nxt  = w_win_wrap ? '0 : r_win + WIN_W'(1);
               if (w_mis) begin
                  w_err_nxt = 1'b1;
                  w_cnt_inc = 1'b1;
               end
               // The wrap-edge bit still belongs to the window that is closing.
               if (w_mis && (w_win_err_inc == WERR_LOSS)) begin
                  w_state_nxt   = SEED;
                  w_lock_nxt    = 1'b0;
                  w_seed_nxt    = '0;
                  w_win_nxt     = '0;
                  w_win_err_nxt = '0;
               end else if (w_win_wrap) begin
                  w_win_err_nxt = '0;
               end else begin
                  w_win_err_nxt = w_win_err_inc;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_lock_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Error counter: clear wins over the old value but keeps an error counted on the same edge.
   always_comb begin
      w_err_cnt_nxt = r_err_cnt;
      if (i_clr) begin
         w_err_cnt_nxt = ERR_W'(w_cnt_inc);
      end else if (w_cnt_inc && !(&r_err_cnt)) begin
         w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Predictor, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr     <= '0;
         r_seed_cnt <= '0;
         r_match    <= '0;
         r_win      <= '0;
         r_win_err  <= '0;
         r_lock     <= 1'b0;
         r_err      <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_lfsr     <= w_lfsr_nxt;
         r_seed_cnt <= w_seed_nxt;
         r_match    <= w_match_nxt;
         r_win      <= w_win_nxt;
         r_win_err  <= w_win_err_nxt;
         r_lock     <= w_lock_nxt;
         r_err      <= w_err_nxt;
         r_err_cnt  <= w_err_cnt_nxt;
      end
   end

   assign o_lock    = r_lock;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__prbs_chk.sv
// Library-style cell wrapper: power pins plus path delays around the functional PRBS7 checker.
// Latency: as the functional core (outputs registered on CLK rise, cleared asynchronously by RN).
// Backpressure: none; I is sampled on every rising CLK.
module gf180mcu_fd_sc_mcu9t5v0__prbs_chk
   import gf180mcu_fd_sc_mcu9t5v0__prbs_chk_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_ERR = 4,
   parameter int LOSS_WIN = 32,
   parameter int ERR_W    = 16
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             EN,
   input  logic             I,
   input  logic             CLR,
   output logic             LOCK,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT,
   inout  wire              VDD,
   inout  wire              VSS
);

   // Supply pins carry no logic; they are only observed here.
   logic w_unused_pwr;
   assign w_unused_pwr = VDD ^ VSS;

   gf180mcu_fd_sc_mcu9t5v0__prbs_chk_func #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_ERR (LOSS_ERR),
      .LOSS_WIN (LOSS_WIN),
      .ERR_W    (ERR_W)
   ) u_func (
      .i_clk     (CLK),
      .i_rst_n   (RN),
      .i_en      (EN),
      .i_bit     (I),
      .i_clr     (CLR),
      .o_lock    (LOCK),
      .o_err     (ERR),
      .o_err_cnt (ERR_CNT)
   );

`ifndef FUNCTIONAL
   specify
      (posedge CLK => (LOCK : I)) = (1.0, 1.0);
      (posedge CLK => (ERR : I)) = (1.0, 1.0);
      (posedge CLK *> (ERR_CNT : I)) = (1.0, 1.0);
      (RN => LOCK) = (1.0, 1.0);
      (RN => ERR) = (1.0, 1.0);
      (RN *> ERR_CNT) = (1.0, 1.0);
   endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__prbs_chk.sv
// Bench for the PRBS7 chain checker: vector table of stream segments plus ERR-pulse scoreboard.
// Latency: expects outputs one edge after the deciding bit.
// Backpressure: n/a.
module tb_gf180mcu_fd_sc_mcu9t5v0__prbs_chk;

   logic        clk = 1'b0;
   logic        rn  = 1'b0;
   logic        en  = 1'b0;
   logic        i_bit = 1'b0;
   logic        clr = 1'b0;
   wire         vdd;
   wire         vss;
   logic        lock0, err0, lock1, err1;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   gf180mcu_fd_sc_mcu9t5v0__prbs_chk u_dut (
      .CLK(clk), .RN(rn), .EN(en), .I(i_bit), .CLR(clr),
      .LOCK(lock0), .ERR(err0), .ERR_CNT(cnt0), .VDD(vdd), .VSS(vss)
   );

   // Narrow-counter copy sharing all stimulus, used for saturation checks.
   gf180mcu_fd_sc_mcu9t5v0__prbs_chk #(.ERR_W(2)) u_dut_w2 (
      .CLK(clk), .RN(rn), .EN(en), .I(i_bit), .CLR(clr),
      .LOCK(lock1), .ERR(err1), .ERR_CNT(cnt1), .VDD(vdd), .VSS(vss)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nbits;     // bits sent in this segment; only the last may be flipped
      bit flip;      // invert the last bit
      bit clr;       // CLR asserted with the last bit
      bit exp_err;   // an ERR pulse is expected for the last bit
      bit exp_lock;  // LOCK after the last bit
      int exp_cnt;   // ERR_CNT (16-bit) after the last bit
      int exp_cnt2;  // ERR_CNT (2-bit) after the last bit
   } vec_t;

   vec_t       vt[$];
   int         err_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;
   logic [6:0] gen    = 7'h7F;
   bit         lock_seen = 1'b0;

   task automatic add(input int n, input bit f, input bit c, input bit e,
                      input bit l, input int c0, input int c2);
      vec_t v;
      v.nbits = n; v.flip = f; v.clr = c; v.exp_err = e;
      v.exp_lock = l; v.exp_cnt = c0; v.exp_cnt2 = c2;
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge pass, then settle the ERR scoreboard.
   task automatic step(input logic e, input logic b, input logic c);
      int x;
      en = e; i_bit = b; clr = c;
      @(posedge clk);
      #1;
      if (lock0) lock_seen = 1'b1;
      if (err_q.size() != 0) begin
         x = err_q.pop_front();
         chk("err_pulse", x, int'(err0), 1);
         chk("err_pulse_w2", x, int'(err1), 1);
         chk("cnt_at_err", x, int'(cnt0), x);
      end else if (err0 || err1) begin
         chk("spurious_err", 0, int'(err0 | err1), 0);
      end
   endtask

   // Next bit of the reference PRBS7 source, optionally inverted.
   task automatic send_bit(input bit flip, input bit c);
      logic b;
      b   = gen[6] ^ gen[5];
      gen = {gen[5:0], b};
      step(1'b1, b ^ flip, c);
   endtask

   task automatic relock(input int idx);
      repeat (22) send_bit(1'b0, 1'b0);
      chk("relock_pre", idx, int'(lock0), 0);
      send_bit(1'b0, 1'b0);
      chk("relock_23", idx, int'(lock0), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, expected completion");
      n_fail++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1);
   end

   initial begin
      //   nbits flip clr err lock cnt cnt2
      add(22, 0, 0, 0, 0, 0, 0);   // 7 seed + 15 verify: not yet locked
      add( 1, 0, 0, 0, 1, 0, 0);   // 23rd bit: lock
      add(10, 1, 0, 1, 1, 1, 1);   // single error while locked
      add( 1, 0, 0, 0, 1, 1, 1);   // following bit predicted correctly
      add(26, 0, 0, 0, 1, 1, 1);   // cross the window wrap
      add( 2, 1, 0, 1, 1, 2, 2);
      add( 2, 1, 0, 1, 1, 3, 3);
      add( 2, 1, 0, 1, 1, 4, 3);
      add( 2, 1, 0, 1, 0, 5, 3);   // 4th error in window: lock lost
      add(22, 0, 0, 0, 0, 5, 3);
      add( 1, 0, 0, 0, 1, 5, 3);   // relock after 23 clean bits
      add(29, 1, 0, 1, 1, 6, 3);   // errors on window bits 29,30,31
      add( 1, 1, 0, 1, 1, 7, 3);
      add( 1, 1, 0, 1, 1, 8, 3);
      add( 1, 1, 0, 1, 0, 9, 3);   // wrap-edge bit counts in old window
      add(22, 0, 0, 0, 0, 9, 3);
      add( 1, 0, 0, 0, 1, 9, 3);
      add( 1, 0, 1, 0, 1, 0, 0);   // clear
      add(40, 1, 0, 1, 1, 1, 1);   // sparse errors: saturate the 2-bit count
      add(40, 1, 0, 1, 1, 2, 2);
      add(40, 1, 0, 1, 1, 3, 3);
      add(40, 1, 0, 1, 1, 4, 3);
      add(40, 1, 0, 1, 1, 5, 3);
      add(40, 1, 1, 1, 1, 1, 1);   // clear and error on one edge
      add(40, 1, 0, 1, 1, 2, 2);
      add(40, 1, 0, 1, 1, 3, 3);
      add(40, 1, 0, 1, 1, 4, 3);
      add(40, 1, 0, 1, 1, 5, 3);

      // Reset state.
      #3;
      chk("rst_lock", 0, int'(lock0), 0);
      chk("rst_err", 0, int'(err0), 0);
      chk("rst_cnt", 0, int'(cnt0), 0);
      chk("rst_lock_w2", 0, int'(lock1), 0);
      chk("rst_cnt_w2", 0, int'(cnt1), 0);
      @(negedge clk);
      rn = 1'b1;
      step(1'b1, 1'b0, 1'b0);   // IDLE -> SEED

      foreach (vt[k]) begin
         for (int j = 0; j < vt[k].nbits - 1; j++) send_bit(1'b0, 1'b0);
         if (vt[k].exp_err) err_q.push_back(vt[k].exp_cnt);
         send_bit(vt[k].flip, vt[k].clr);
         chk("lock", k, int'(lock0), int'(vt[k].exp_lock));
         chk("cnt", k, int'(cnt0), vt[k].exp_cnt);
         chk("cnt_w2", k, int'(cnt1), vt[k].exp_cnt2);
      end

      // Asynchronous reset while ERR is high and ERR_CNT=5: outputs clear without an edge.
      #1 rn = 1'b0;
      #1;
      chk("arst_lock", 0, int'(lock0), 0);
      chk("arst_err", 0, int'(err0), 0);
      chk("arst_cnt", 0, int'(cnt0), 0);
      chk("arst_cnt_w2", 0, int'(cnt1), 0);
      step(1'b1, 1'b1, 1'b0);
      chk("arst_hold_lock", 0, int'(lock0), 0);
      #2 rn = 1'b1;
      step(1'b1, 1'b0, 1'b0);   // IDLE -> SEED
      relock(0);
      chk("arst_relock_cnt", 0, int'(cnt0), 0);

      // EN low while locked: lock drops, count retained, no ERR even on a bad bit.
      err_q.push_back(1);
      send_bit(1'b1, 1'b0);
      chk("en_pre_cnt", 0, int'(cnt0), 1);
      step(1'b0, ~(gen[6] ^ gen[5]), 1'b0);
      chk("en_off_lock", 0, int'(lock0), 0);
      chk("en_off_cnt", 0, int'(cnt0), 1);
      step(1'b1, 1'b0, 1'b0);   // IDLE -> SEED
      relock(1);

      // Stuck-at-0 then stuck-at-1 chain: never locks, never counts.
      step(1'b0, 1'b0, 1'b1);
      chk("stuck_clr_cnt", 0, int'(cnt0), 0);
      lock_seen = 1'b0;
      repeat (200) step(1'b1, 1'b0, 1'b0);
      chk("stuck0_lock", 0, int'(lock_seen), 0);
      chk("stuck0_cnt", 0, int'(cnt0), 0);
      repeat (60) step(1'b1, 1'b1, 1'b0);
      chk("stuck1_lock", 0, int'(lock_seen), 0);
      chk("stuck1_cnt", 0, int'(cnt0), 0);
      chk("err_q_empty", 0, err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
